// File: rtl/dna_pkg.sv
// Shared encodings for the DNA search scheduler: base one-hot codes,
// FSM state encoding and the per-base bit width.
package dna_pkg;

  localparam int BASE_BITS = 4;

  localparam logic [BASE_BITS-1:0] BASE_A = 4'b0001;
  localparam logic [BASE_BITS-1:0] BASE_C = 4'b0010;
  localparam logic [BASE_BITS-1:0] BASE_G = 4'b0100;
  localparam logic [BASE_BITS-1:0] BASE_T = 4'b1000;

  typedef enum logic [6:0] {
    ST_IDLE   = 7'b0000001,
    ST_SRST   = 7'b0000010,
    ST_START  = 7'b0000100,
    ST_WAIT   = 7'b0001000,
    ST_HIT    = 7'b0010000,
    ST_FINISH = 7'b0100000,
    ST_SPARE  = 7'b1000000
  } state_t;

endpackage

// File: rtl/dna_result_fifo.sv
// Synchronous FIFO, one-cycle write-to-read latency, head always visible.
// Push is ignored when full and pop when empty; the producer must watch full.
module dna_result_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/dna_search_scheduler.sv
// Job controller relaunching one DNASearcher until every pattern hit is found.
// Hits stream through a small FIFO; a full FIFO stalls the job in HIT.
module dna_search_scheduler
  import dna_pkg::*;
#(
  parameter int BIG_SEQ_SIZE            = 32,
  parameter int SMALL_SEQ_SIZE          = 8,
  parameter int OUTER_LOCATION_NUM_SIZE = 5,
  parameter int FIFO_DEPTH              = 4,
  parameter int TIMEOUT_CYCLES          = 256,
  parameter int MAX_HITS                = 8
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               job_valid,
  output logic                               job_ready,
  input  logic [BIG_SEQ_SIZE-1:0]            job_big,
  input  logic [SMALL_SEQ_SIZE-1:0]          job_small,
  output logic                               srch_rst_n,
  output logic                               srch_start,
  output logic [BIG_SEQ_SIZE-1:0]            srch_big,
  output logic [SMALL_SEQ_SIZE-1:0]          srch_small,
  output logic [OUTER_LOCATION_NUM_SIZE-1:0] srch_start_index,
  input  logic                               srch_done,
  input  logic                               srch_found,
  input  logic [OUTER_LOCATION_NUM_SIZE-1:0] srch_location,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [OUTER_LOCATION_NUM_SIZE-1:0] res_location,
  output logic                               job_done,
  output logic [$clog2(MAX_HITS+1)-1:0]      job_hits,
  output logic                               job_timeout
);

  localparam int LW = OUTER_LOCATION_NUM_SIZE;
  localparam int HW = $clog2(MAX_HITS+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [LW-1:0] IDX_TOP      = LW'(BIG_SEQ_SIZE - 1);
  localparam logic [LW-1:0] MIN_RELAUNCH = LW'(SMALL_SEQ_SIZE - 1 + BASE_BITS);
  localparam logic [LW-1:0] BASE_STEP    = LW'(BASE_BITS);
  localparam logic [HW-1:0] HITS_CAP     = HW'(MAX_HITS);
  // Compared against the pre-increment value, so FINISH lands exactly
  // TIMEOUT_CYCLES cycles after START.
  localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT_CYCLES - 2);

  state_t state_q, state_d;

  logic [BIG_SEQ_SIZE-1:0]   big_q;
  logic [SMALL_SEQ_SIZE-1:0] small_q;
  logic [LW-1:0]             idx_q;
  logic [HW-1:0]             hits_q;
  logic [HW-1:0]             hits_nxt;
  logic [TW-1:0]             timer_q;
  logic                      timeout_q;

  logic accept;
  logic relaunch;
  logic push;
  logic timer_clr;
  logic timer_inc;
  logic set_tmo;
  logic fifo_full;
  logic fifo_empty;
  logic pop;

  assign hits_nxt         = hits_q + HW'(1);
  assign srch_big         = big_q;
  assign srch_small       = small_q;
  assign srch_start_index = idx_q;
  assign job_hits         = hits_q;
  assign job_timeout      = timeout_q;
  assign res_valid        = !fifo_empty;
  assign pop              = res_valid && res_ready;

  always_ff @(posedge CLK) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    job_ready  = 1'b0;
    srch_rst_n = 1'b0;
    srch_start = 1'b0;
    job_done   = 1'b0;
    accept     = 1'b0;
    relaunch   = 1'b0;
    push       = 1'b0;
    timer_clr  = 1'b0;
    timer_inc  = 1'b0;
    set_tmo    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        job_ready = 1'b1;
        if (job_valid) begin
          accept  = 1'b1;
          state_d = ST_SRST;
        end
      end
      ST_SRST: state_d = ST_START;
      ST_START: begin
        srch_rst_n = 1'b1;
        srch_start = 1'b1;
        timer_clr  = 1'b1;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        srch_rst_n = 1'b1;
        timer_inc  = 1'b1;
        if (srch_done) begin
          state_d = srch_found ? ST_HIT : ST_FINISH;
        end else if (timer_q == TMO_LAST) begin
          set_tmo = 1'b1;
          state_d = ST_FINISH;
        end
      end
      ST_HIT: begin
        // Searcher stays out of reset so its location holds while we stall.
        srch_rst_n = 1'b1;
        if (!fifo_full) begin
          push = 1'b1;
          if (hits_nxt == HITS_CAP || srch_location < MIN_RELAUNCH) begin
            state_d = ST_FINISH;
          end else begin
            relaunch = 1'b1;
            state_d  = ST_SRST;
          end
        end
      end
      ST_FINISH: begin
        job_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      big_q     <= '0;
      small_q   <= '0;
      idx_q     <= IDX_TOP;
      hits_q    <= '0;
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        big_q     <= job_big;
        small_q   <= job_small;
        idx_q     <= IDX_TOP;
        hits_q    <= '0;
        timeout_q <= 1'b0;
      end
      // Restart one base below the hit so overlapping matches are found.
      if (relaunch) idx_q <= srch_location - BASE_STEP;
      if (push)     hits_q <= hits_nxt;
      if (set_tmo)  timeout_q <= 1'b1;
      if (timer_clr)      timer_q <= '0;
      else if (timer_inc) timer_q <= timer_q + 1'b1;
    end
  end

  dna_result_fifo #(
    .WIDTH (LW),
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (push),
    .push_dat (srch_location),
    .pop      (pop),
    .head_dat (res_location),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_dna_search_scheduler.sv
// Directed bench for dna_search_scheduler with a behavioural searcher stub.
`timescale 1ns/1ps
module tb_dna_search_scheduler;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [31:0] job_big = '0;
  logic [7:0]  job_small = '0;
  logic        srch_rst_n;
  logic        srch_start;
  logic [31:0] srch_big;
  logic [7:0]  srch_small;
  logic [4:0]  srch_start_index;
  logic        srch_done = 1'b0;
  logic        srch_found = 1'b0;
  logic [4:0]  srch_location = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [4:0]  res_location;
  logic        job_done;
  logic [3:0]  job_hits;
  logic        job_timeout;

  dna_search_scheduler dut (
    .CLK              (CLK),
    .RST              (RST),
    .job_valid        (job_valid),
    .job_ready        (job_ready),
    .job_big          (job_big),
    .job_small        (job_small),
    .srch_rst_n       (srch_rst_n),
    .srch_start       (srch_start),
    .srch_big         (srch_big),
    .srch_small       (srch_small),
    .srch_start_index (srch_start_index),
    .srch_done        (srch_done),
    .srch_found       (srch_found),
    .srch_location    (srch_location),
    .res_valid        (res_valid),
    .res_ready        (res_ready),
    .res_location     (res_location),
    .job_done         (job_done),
    .job_hits         (job_hits),
    .job_timeout      (job_timeout)
  );

  always #5 CLK = ~CLK;

  // Searcher stub: scans downward one base at a time, answers a few cycles
  // after START, keeps its answer until its reset is pulled low.
  bit        stub_hang = 1'b0;
  bit        stub_busy = 1'b0;
  int        stub_cnt = 0;
  bit        pf;
  logic [4:0] pl;

  function automatic void search(input logic [31:0] big, input logic [7:0] sm,
                                 input logic [4:0] st, output bit f, output logic [4:0] l);
    f = 1'b0;
    l = '0;
    for (int p = int'(st); p >= 7; p -= 4) begin
      if (!f && big[p -: 8] == sm) begin
        f = 1'b1;
        l = p[4:0];
      end
    end
  endfunction

  always @(posedge CLK) begin
    if (!srch_rst_n) begin
      srch_done     <= 1'b0;
      srch_found    <= 1'b0;
      srch_location <= '0;
      stub_busy     <= 1'b0;
    end else if (srch_start) begin
      if (!stub_hang) begin
        search(srch_big, srch_small, srch_start_index, pf, pl);
        stub_busy <= 1'b1;
        stub_cnt  <= 3;
      end
    end else if (stub_busy) begin
      if (stub_cnt == 0) begin
        srch_done     <= 1'b1;
        srch_found    <= pf;
        srch_location <= pl;
        stub_busy     <= 1'b0;
      end else begin
        stub_cnt <= stub_cnt - 1;
      end
    end
  end

  // Monitor, sampled on the falling edge.
  int cyc = 0;
  int done_cnt = 0, done_cycle = 0, start_cnt = 0, start_cycle = 0;
  int acc_cnt = 0, acc_cycle = 0, valid_cycles = 0;
  int low_run = 0, pre_start_low = 0;
  int last_hits = 0, last_tmo = 0;
  logic [4:0] got[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (res_valid) valid_cycles++;
    if (res_valid && res_ready) got.push_back(res_location);
    if (job_valid && job_ready) begin
      acc_cnt++;
      acc_cycle = cyc;
    end
    if (job_done) begin
      done_cnt++;
      done_cycle = cyc;
      last_hits  = int'(job_hits);
      last_tmo   = int'(job_timeout);
    end
    if (srch_start) begin
      start_cnt++;
      start_cycle   = cyc;
      pre_start_low = low_run;
      low_run       = 0;
    end else if (job_ready) begin
      low_run = 0;
    end else if (!srch_rst_n) begin
      low_run++;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic nb();
    @(negedge CLK);
    #1;
  endtask

  task automatic pb();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_job(input logic [31:0] big, input logic [7:0] sm);
    int i;
    pb();
    job_valid = 1'b1;
    job_big   = big;
    job_small = sm;
    for (i = 0; i < 400; i++) begin
      nb();
      if (job_ready) break;
    end
    if (i == 400) chk("job_accept", 32'(job_ready), 32'd1);
    pb();
    job_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt >= exp) break;
      nb();
    end
    chk(tag, done_cnt, exp);
  endtask

  int d0, s0, v0, a0, i;
  int exp_bp[7] = '{31, 27, 23, 19, 15, 11, 7};

  initial begin
    // Reset state
    RST = 1'b0;
    pb(); pb();
    nb();
    chk("rst_job_ready", 32'(job_ready), 32'd1);
    chk("rst_srch_rst_n", 32'(srch_rst_n), 32'd0);
    chk("rst_srch_start", 32'(srch_start), 32'd0);
    chk("rst_start_index", 32'(srch_start_index), 32'd31);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_job_done", 32'(job_done), 32'd0);
    chk("rst_job_hits", 32'(job_hits), 32'd0);
    chk("rst_job_timeout", 32'(job_timeout), 32'd0);
    pb();
    RST = 1'b1;

    // Multiple hits: ACGTACGT / AC
    got.delete();
    s0 = start_cnt;
    send_job(32'h1248_1248, 8'h12);
    wait_done(1, 300, "mh_done");
    repeat (3) nb();
    chk("mh_count", got.size(), 32'd2);
    if (got.size() == 2) begin
      chk("mh_loc0", 32'(got[0]), 32'd31);
      chk("mh_loc1", 32'(got[1]), 32'd15);
    end
    chk("mh_hits", last_hits, 32'd2);
    chk("mh_timeout", last_tmo, 32'd0);
    chk("mh_runs", start_cnt - s0, 32'd3);

    // No match
    got.delete();
    s0 = start_cnt;
    v0 = valid_cycles;
    send_job(32'h8888_8888, 8'h12);
    wait_done(2, 300, "nm_done");
    repeat (3) nb();
    chk("nm_valid_cycles", valid_cycles - v0, 32'd0);
    chk("nm_hits", last_hits, 32'd0);
    chk("nm_runs", start_cnt - s0, 32'd1);
    chk("nm_rst_low", pre_start_low, 32'd1);

    // Backpressure: all-A sequence, consumer stalled
    got.delete();
    s0 = start_cnt;
    res_ready = 1'b0;
    send_job(32'h1111_1111, 8'h11);
    repeat (80) nb();
    chk("bp_stall_runs", start_cnt - s0, 32'd5);
    chk("bp_stall_ready", 32'(job_ready), 32'd0);
    chk("bp_no_done", done_cnt, 32'd2);
    chk("bp_head_valid", 32'(res_valid), 32'd1);
    chk("bp_head_loc", 32'(res_location), 32'd31);
    pb();
    res_ready = 1'b1;
    wait_done(3, 300, "bp_done");
    repeat (3) nb();
    chk("bp_count", got.size(), 32'd7);
    if (got.size() == 7)
      for (int k = 0; k < 7; k++) chk($sformatf("bp_loc%0d", k), 32'(got[k]), exp_bp[k]);
    chk("bp_hits", last_hits, 32'd7);

    // Timeout: searcher never answers
    stub_hang = 1'b1;
    send_job(32'h1248_1248, 8'h12);
    wait_done(4, 400, "to_done");
    chk("to_latency", done_cycle - start_cycle, 32'd256);
    chk("to_flag", last_tmo, 32'd1);
    chk("to_hits", last_hits, 32'd0);
    nb();
    chk("to_ready_after", 32'(job_ready), 32'd1);
    stub_hang = 1'b0;

    // Handshake: job_valid held through a running job
    a0 = acc_cnt;
    pb();
    job_valid = 1'b1;
    job_big   = 32'h1248_1248;
    job_small = 8'h12;
    wait_done(5, 300, "hs_done1");
    nb();
    chk("hs_ready_idle", 32'(job_ready), 32'd1);
    chk("hs_accepts", acc_cnt - a0, 32'd2);
    chk("hs_accept_cycle", acc_cycle - done_cycle, 32'd1);
    pb();
    job_valid = 1'b0;
    nb();
    chk("hs_fresh_index", 32'(srch_start_index), 32'd31);
    wait_done(6, 300, "hs_done2");
    chk("hs_hits2", last_hits, 32'd2);

    // Reset during WAIT with FIFO holding entries
    repeat (3) nb();
    res_ready = 1'b0;
    send_job(32'h1111_1111, 8'h11);
    for (i = 0; i < 100; i++) begin
      nb();
      if (srch_rst_n && !srch_start && !srch_done && res_valid) break;
    end
    chk("rm_reached_wait", 32'(i < 100), 32'd1);
    d0 = done_cnt;
    RST = 1'b0;
    pb();
    chk("rm_job_ready", 32'(job_ready), 32'd1);
    chk("rm_srch_rst_n", 32'(srch_rst_n), 32'd0);
    chk("rm_res_valid", 32'(res_valid), 32'd0);
    RST = 1'b1;
    res_ready = 1'b1;
    repeat (10) nb();
    chk("rm_no_done", done_cnt, d0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule

// File: doc/dna_search_scheduler.md
Name: dna_search_scheduler

Overview:
- Job controller that sequences one DNASearcher datapath instance to find every occurrence of a short pattern in a long sequence.
- Accepts jobs over a valid/ready interface and launches the searcher repeatedly. Each relaunch restarts the search one base below the previous hit.
- Pulses the searcher's reset between runs, because the searcher's COMPLETE state is sticky.
- Streams hit locations through an internal result FIFO, then reports a per-job summary.

Parameters:
BIG_SEQ_SIZE, 32, bits of big sequence (4-bit one-hot bases, MSB = first base)
SMALL_SEQ_SIZE, 8, bits of pattern
OUTER_LOCATION_NUM_SIZE, 5, width of bit-index/location
FIFO_DEPTH, 4, result FIFO entries (power of 2)
TIMEOUT_CYCLES, 256, max cycles per searcher run before abort
MAX_HITS, 8, hit cap per job (count width = clog2(MAX_HITS+1))

Ports:
CLK  in  1  clock
RST  in  1  synchronous, active-low reset
job_valid  in  1  job offered
job_ready  out  1  scheduler idle, accepts job
job_big  in  BIG_SEQ_SIZE  sequence to search
job_small  in  SMALL_SEQ_SIZE  pattern
srch_rst_n  out  1  drives searcher RST
srch_start  out  1  drives searcher START
srch_big  out  BIG_SEQ_SIZE  registered job_big
srch_small  out  SMALL_SEQ_SIZE  registered job_small
srch_start_index  out  OUTER_LOCATION_NUM_SIZE  next start bit index
srch_done  in  1  searcher DONE
srch_found  in  1  searcher found
srch_location  in  OUTER_LOCATION_NUM_SIZE  searcher location
res_valid  out  1  hit location available
res_ready  in  1  consumer takes hit
res_location  out  OUTER_LOCATION_NUM_SIZE  hit bit index (MSB of matching base)
job_done  out  1  one-cycle pulse at job end
job_hits  out  clog2(MAX_HITS+1)  hits for finished job, valid with job_done
job_timeout  out  1  sticky per job, valid with job_done

Behaviour:
- Reset (RST=0 at posedge): state IDLE; job_ready=1; srch_rst_n=0; srch_start=0; srch_start_index=BIG_SEQ_SIZE-1; FIFO emptied; res_valid=0; job_done=0; job_hits=0; job_timeout=0; hit counter and timer cleared. Reset mid-job abandons the job with no job_done pulse.
- FSM:
  - IDLE: srch_rst_n=0. On job_valid&&job_ready, register big/small, set index=BIG_SEQ_SIZE-1, clear hits and timeout flag, go SRST.
  - SRST: srch_rst_n=0 for exactly 1 cycle, then go START.
  - START: srch_rst_n=1, srch_start=1 for 1 cycle, clear timer, go WAIT.
  - WAIT: srch_rst_n=1, timer increments.
    - On srch_done=1: if srch_found=1, go HIT; otherwise go FINISH.
    - If timer reaches TIMEOUT_CYCLES-1 before done, set job_timeout and go FINISH.
  - HIT: stalls while the FIFO is full, with srch_rst_n held at 1. When the FIFO is not full, push srch_location and increment hits.
    - Go FINISH if hits+1==MAX_HITS, or if srch_location < SMALL_SEQ_SIZE-1+4 (no room for another match).
    - Otherwise set index=srch_location-4 and go SRST.
  - FINISH: pulse job_done for 1 cycle with job_hits/job_timeout, then go IDLE.
- job_ready=1 only in IDLE. Job input is not registered outside the handshake.
- srch_big/srch_small/srch_start_index stay stable from SRST through WAIT.
- Result FIFO:
  - Push happens only in HIT.
  - Pop when res_valid&&res_ready.
  - Simultaneous push and pop when full is not allowed: HIT waits for a non-full FIFO.
  - Simultaneous push and pop when not full keeps the count.
  - Pointers wrap modulo FIFO_DEPTH.
  - res_location is driven from the FIFO head. res_valid = !empty.
- FIFO entries outlive the job and drain after job_done. A new job may start while the FIFO holds old entries.
- Location arithmetic is unsigned. The guard prevents underflow of srch_location-4.

Decomposition:
- dna_pkg holds:
  - base encodings A=4'b0001, C=4'b0010, G=4'b0100, T=4'b1000;
  - state encoding, one-hot 7-bit: IDLE, SRST, START, WAIT, HIT, FINISH, spare;
  - BASE_BITS=4.
- Sub-module dna_result_fifo: parameterised synchronous FIFO with full/empty, width OUTER_LOCATION_NUM_SIZE.

Test Plan:
- Multiple hits: big=32'h1248_1248 (ACGTACGT), small=8'h12 (AC), res_ready=1 -> res_location 31 then 15; job_done with job_hits=2, job_timeout=0.
- No match: big=32'h8888_8888, small=8'h12 -> no res_valid; job_done with job_hits=0. Exactly one searcher run; srch_rst_n low exactly 1 cycle before it.
- Backpressure: big=32'h1111_1111, small=8'h11, FIFO_DEPTH=4, res_ready=0 -> 4 entries pushed (31,27,23,19), scheduler stalls in HIT. Raise res_ready -> remaining hits 15,11,7; job_hits=7.
- Timeout: stub searcher never asserts srch_done -> job_done exactly TIMEOUT_CYCLES cycles after START; job_timeout=1; job_hits=0; job_ready=1 next cycle.
- Reset mid-job: assert RST=0 during WAIT -> next cycle job_ready=1, srch_rst_n=0, res_valid=0, no job_done pulse.
- Handshake: job_valid held high during a running job -> ignored until IDLE. Second job accepted the cycle after job_done, with fresh srch_start_index=31.
